memcode_rom_arbiter: RTL

- Shares one single-port memory-code ROM (32-bit words, 14-bit address, 1-cycle read latency) between NUM_CH memory PRN code generator channels and one CPU readback port.
- Grants one read per cycle: CPU first with anti-starvation alternation, channels round-robin.
- The grant pulse drives each channel's read-valid input. ROM data is broadcast to all channels one cycle after the grant.
- Sits between the correlator channel array and the code ROM macro.

---
 rtl/memcode_rom_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/memcode_rom_arbiter.sv
// memcode_rom_arbiter: shares one code ROM between NUM_CH PRN
// channels and a CPU readback port, one read per cycle.
module memcode_rom_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH-1:0]    ch_rd,
  input  logic [NUM_CH*14-1:0] ch_addr,
  output logic [NUM_CH-1:0]    ch_gnt,
  output logic [31:0]          memcode_data,
  input  logic                 cpu_rd,
  input  logic [13:0]          cpu_addr,
  output logic                 cpu_ack,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_rdata_valid,
  output logic                 rom_cs,
  output logic [13:0]          rom_addr,
  input  logic [31:0]          rom_rdata,
  output logic                 rdata_valid,
  output logic [4:0]           rdata_src
);

  logic [NUM_CH-1:0] eff;
  logic              hi_vld;
  logic              lo_vld;
  logic [PTR_W-1:0]  hi_idx;
  logic [PTR_W-1:0]  lo_idx;
  logic [PTR_W-1:0]  ch_idx;
  logic              ch_go;
  logic              cpu_go;
  logic              cpu_hit;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              last_cpu_q, last_cpu_d;
  logic              rdv_q, rdv_d;
  logic [4:0]        src_q, src_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rv_q, cpu_rv_d;

  // Round-robin search: lowest request above the pointer, else lowest overall.
  always_comb begin
    eff    = ch_rd & ch_enable;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (eff[j]) begin
        lo_vld = 1'b1;
        lo_idx = PTR_W'(j);
        if (PTR_W'(j) > rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = PTR_W'(j);
        end
      end
    end
    ch_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Grant decision and ROM request; CPU yields every other slot under contention.
  always_comb begin
    cpu_go   = rst_b & cpu_rd & ~(last_cpu_q & (|eff));
    ch_go    = rst_b & ~cpu_go & (hi_vld | lo_vld);
    cpu_ack  = cpu_go;
    ch_gnt   = ch_go ? (NUM_CH'(1) << ch_idx) : '0;
    rom_cs   = cpu_go | ch_go;
    rom_addr = cpu_go ? cpu_addr : 14'h0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (ch_gnt[j]) rom_addr = ch_addr[j*14 +: 14];
    end
  end

  // Next-state: pointer, alternation flag and return-path tags.
  always_comb begin
    rr_ptr_d    = ch_go ? ch_idx : rr_ptr_q;
    last_cpu_d  = cpu_go;
    rdv_d       = rom_cs;
    src_d       = src_q;
    if (cpu_go) begin
      src_d = 5'h10;
    end else if (ch_go) begin
      src_d = {1'b0, 4'(ch_idx)};
    end
    cpu_hit     = rdv_q & src_q[4];
    cpu_rdata_d = cpu_hit ? rom_rdata : cpu_rdata_q;
    cpu_rv_d    = cpu_hit;
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rr_ptr_q    <= PTR_W'(NUM_CH - 1);
      last_cpu_q  <= 1'b0;
      rdv_q       <= 1'b0;
      src_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_rv_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_cpu_q  <= last_cpu_d;
      rdv_q       <= rdv_d;
      src_q       <= src_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_rv_q    <= cpu_rv_d;
    end
  end

  assign memcode_data    = rom_rdata;
  assign rdata_valid     = rdv_q;
  assign rdata_src       = src_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_rdata_valid = cpu_rv_q;

endmodule
